// File: rtl/bus_xcvr_pkg.sv
// bus_xcvr_pkg: state encoding and parameter defaults shared by bus_xcvr_seq.
package bus_xcvr_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
  localparam int TURN_CYCLES_DEF = 1;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/bus_xcvr_seq.sv
// bus_xcvr_seq: transfer sequencer for a bidirectional bus transceiver with strobe_n/dtack_n handshake.
// Define BUS_XCVR_SEQ_TIMEOUT_EN to bound the dtack_n wait to TIMEOUT STROBE cycles.
module bus_xcvr_seq
  import bus_xcvr_pkg::*;
#(
  parameter int TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic       err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       T_n,
  output logic       R_n,
  output logic [7:0] a_out,
  output logic       a_oe,
  input  logic [7:0] a_in,
  output logic       strobe_n,
  input  logic       dtack_n
);
  state_t state;
  logic [3:0] tc;
  logic lwe;
  logic [7:0] lwd;
  logic dir;
  logic timeout;
  if (TURN_CYCLES < 1 || TURN_CYCLES > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("bus_xcvr_seq: TURN_CYCLES or TIMEOUT out of range");
  end
`ifdef BUS_XCVR_SEQ_TIMEOUT_EN
  logic [7:0] cnt;
  logic to_flag;
  assign timeout = cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      to_flag <= 1'b0;
    end else if (state == SETUP) begin
      cnt <= '0;
      to_flag <= 1'b0;
    end else if (state == STROBE) begin
      cnt <= cnt + 8'd1;
      to_flag <= dtack_n && timeout;
    end
  assign err = state == HOLD && to_flag;
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      tc <= '0;
      lwe <= 1'b0;
      lwd <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= SETUP;
          lwe <= we;
          lwd <= wdata;
        end
        SETUP: state <= STROBE;
        STROBE: if (!dtack_n) begin
          state <= HOLD;
          if (!lwe) rdata <= a_in;
        end else if (timeout) state <= HOLD;
        HOLD: begin
          state <= TURN;
          tc <= '0;
        end
        TURN: if (tc == 4'(TURN_CYCLES - 1)) state <= IDLE; else tc <= tc + 4'd1;
        default: state <= IDLE;
      endcase
    end
  // Outputs decode straight from state so an async reset releases the bus at once.
  assign dir = state == SETUP || state == STROBE || state == HOLD;
  assign T_n = !(dir && lwe);
  assign R_n = !(dir && !lwe);
  assign a_oe = dir && lwe;
  assign a_out = a_oe ? lwd : '0;
  assign strobe_n = state != STROBE;
  assign ack = state == HOLD;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_bus_xcvr_seq.sv
// tb_bus_xcvr_seq: directed scenarios plus randomized traffic checked against a cycle-indexed transfer model.
module tb_bus_xcvr_seq;
  localparam int TC = 1;
  localparam int TO = 8;
  typedef enum int {P_IDLE, P_SETUP, P_STROBE, P_HOLD, P_TURN} ph_t;
  logic clk = 1'b0, reset_n = 1'b0, req = 1'b0, we = 1'b0, dtack_n = 1'b1;
  logic [7:0] wdata = '0, a_in = '0;
  logic ack, err, busy, T_n, R_n, a_oe, strobe_n;
  logic [7:0] rdata, a_out;
  int n_cmp = 0, n_bad = 0, cyc = 0, acks = 0;
  bit m_act = 0, m_we = 0, m_err = 0;
  int s = 0, se = -1;
  logic [7:0] m_wd = '0, m_rd = '0;
  ph_t p;
  logic dir, eoe;

  bus_xcvr_seq #(.TURN_CYCLES(TC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .T_n(T_n), .R_n(R_n),
    .a_out(a_out), .a_oe(a_oe), .a_in(a_in), .strobe_n(strobe_n), .dtack_n(dtack_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string nm, input logic act, input logic want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, want);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a transfer accepted at cycle s has SETUP at s+1, STROBE from s+2 until dtack_n
  // is seen low at cycle se, HOLD at se+1, TURN for TC cycles, then IDLE.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk1("rst_tn", T_n, 1'b1);
      chk1("rst_rn", R_n, 1'b1);
      chk1("rst_stb", strobe_n, 1'b1);
      chk1("rst_aoe", a_oe, 1'b0);
      chk8("rst_aout", a_out, 8'h00);
      chk1("rst_ack", ack, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk8("rst_rdata", rdata, 8'h00);
      m_act = 0;
      m_rd = '0;
    end else begin
      if (m_act && se >= 0 && cyc > se + 1 + TC) m_act = 0;
      p = !m_act ? P_IDLE : cyc == s + 1 ? P_SETUP : se < 0 ? P_STROBE : cyc == se + 1 ? P_HOLD : P_TURN;
      dir = p == P_SETUP || p == P_STROBE || p == P_HOLD;
      eoe = dir && m_we;
      chk1("m_tn", T_n, !eoe);
      chk1("m_rn", R_n, !(dir && !m_we));
      chk1("m_aoe", a_oe, eoe);
      if (eoe) chk8("m_aout", a_out, m_wd);
      chk1("m_stb", strobe_n, p != P_STROBE);
      chk1("m_ack", ack, p == P_HOLD);
      chk1("m_err", err, p == P_HOLD && m_err);
      chk1("m_busy", busy, p != P_IDLE);
      chk8("m_rdata", rdata, m_rd);
      if (p == P_IDLE && req) begin
        m_act = 1; s = cyc; se = -1; m_we = we; m_wd = wdata; m_err = 0;
      end else if (p == P_STROBE) begin
        if (!dtack_n) begin
          se = cyc;
          if (!m_we) m_rd = a_in;
        end
`ifdef BUS_XCVR_SEQ_TIMEOUT_EN
        else if (cyc - s - 1 == TO) begin
          se = cyc;
          m_err = 1;
        end
`endif
      end
    end
  end

  initial begin
    @(negedge clk);
    chk1("init_busy", busy, 1'b0);
    chk1("init_tn", T_n, 1'b1);
    step();
    reset_n = 1'b1;
    // Write A5, dtack_n already low; this cycle is also the first edge after reset release.
    req = 1'b1; we = 1'b1; wdata = 8'hA5; dtack_n = 1'b0;
    step();
    req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk1("wr_tn", T_n, c > 3);
      chk1("wr_rn", R_n, 1'b1);
      chk1("wr_stb", strobe_n, c != 2);
      chk1("wr_ack", ack, c == 3);
      if (c <= 3) chk8("wr_aout", a_out, 8'hA5);
      step();
    end
    // Read 3C with dtack_n low in the fourth STROBE cycle.
    req = 1'b1; we = 1'b0; a_in = 8'h3C; dtack_n = 1'b1;
    step();
    req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk1("rd_tn", T_n, 1'b1);
      chk1("rd_rn", R_n, c > 6);
      chk1("rd_ack", ack, c == 6);
      if (c == 6) chk8("rd_rdata", rdata, 8'h3C);
      step();
      if (c == 4) dtack_n = 1'b0;
    end
    // Write then read with req held high.
    req = 1'b1; we = 1'b1; wdata = 8'h5A; dtack_n = 1'b0;
    step();
    we = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk1("b2b_rn4", R_n, 1'b1);
        chk1("b2b_tn4", T_n, 1'b1);
      end
      if (c == 5) chk1("b2b_idle5", busy, 1'b0);
      if (c == 6) begin
        chk1("b2b_rn6", R_n, 1'b0);
        chk1("b2b_tn6", T_n, 1'b1);
      end
      if (c == 8) chk1("b2b_ack8", ack, 1'b1);
      chk1("b2b_excl", T_n | R_n, 1'b1);
      step();
      if (c == 5) req = 1'b0;
    end
    // req pulsed during STROBE must not start a second transfer.
    req = 1'b1; we = 1'b1; wdata = 8'hC3; dtack_n = 1'b1;
    step();
    req = 1'b0;
    acks = 0;
    step();
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    dtack_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      acks += int'(ack);
      step();
    end
    chk8("pulse_acks", 8'(acks), 8'd1);
    chk1("pulse_idle", busy, 1'b0);
    // Reset in STROBE releases the bus without a clock edge.
    req = 1'b1; we = 1'b1; wdata = 8'h77; dtack_n = 1'b1;
    step();
    req = 1'b0;
    step();
    @(negedge clk);
    chk1("rs_stb_pre", strobe_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk1("rs_tn", T_n, 1'b1);
    chk1("rs_rn", R_n, 1'b1);
    chk1("rs_stb", strobe_n, 1'b1);
    chk1("rs_aoe", a_oe, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    req = 1'b1; we = 1'b0; a_in = 8'h5A; dtack_n = 1'b0;
    step();
    req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk1("rs_ack", ack, c == 3);
      if (c == 3) chk8("rs_rdata", rdata, 8'h5A);
      step();
    end
`ifdef BUS_XCVR_SEQ_TIMEOUT_EN
    req = 1'b1; we = 1'b0; a_in = 8'hEE; dtack_n = 1'b1;
    step();
    req = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk1("to_ack", ack, c == 10);
      chk1("to_err", err, c == 10);
      if (c == 10) chk8("to_rdata", rdata, 8'h5A);
      step();
    end
`endif
    repeat (600) begin
      req = $urandom_range(0, 2) == 0;
      we = 1'($urandom);
      wdata = 8'($urandom);
      a_in = 8'($urandom);
      dtack_n = $urandom_range(0, 2) != 0;
      reset_n = $urandom_range(0, 149) != 0;
      step();
    end
    reset_n = 1'b1;
    req = 1'b0;
    repeat (20) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_xcvr_seq.md
BUS_XCVR_SEQ -- requirements
Module: bus_xcvr_seq

Interface
REQ-001 The module SHALL have parameter TURN_CYCLES, default 1, giving the number of cycles T_n and R_n are both high after each transfer (legal range 1..15).
REQ-002 The module SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles spent waiting for dtack_n (legal range 1..255).
REQ-003 Ports SHALL be as follows; one clock, reset asynchronous and active-low:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  local transfer request; sampled only in IDLE.
- we  in  1  1 = write (A->B), 0 = read (B->A); captured on acceptance.
- wdata  in  8  write data; captured on acceptance.
- ack  out  1  one-cycle pulse at transfer completion.
- err  out  1  one-cycle pulse with ack on timeout (timeout build only).
- rdata  out  8  read data; holds its value until the next read completes.
- busy  out  1  high in every state except IDLE.
- T_n  out  1  transceiver transmit enable, active low.
- R_n  out  1  transceiver receive enable, active low.
- a_out  out  8  data driven onto the transceiver A side.
- a_oe  out  1  A-side drive enable.
- a_in  in  8  A-side bus value, used on reads.
- strobe_n  out  1  remote data strobe, active low.
- dtack_n  in  1  remote acknowledge, active low; synchronous to clk.

Function
REQ-004 The module SHALL implement the states IDLE, SETUP, STROBE, HOLD and TURN.
REQ-005 IDLE SHALL behave as follows:
- With req=1, the module latches we and wdata and goes to SETUP next cycle.
- A req arriving in any other state is ignored; it is not queued.
REQ-006 SETUP SHALL last exactly one cycle, then go to STROBE:
- Write: T_n=0, R_n=1, a_oe=1, a_out=latched wdata.
- Read: R_n=0, T_n=1, a_oe=0.
REQ-007 STROBE SHALL behave as follows:
- strobe_n=0, with the direction outputs held from SETUP.
- The module stays in STROBE until it samples dtack_n=0.
REQ-008 On a read, rdata SHALL load a_in on the same edge that samples dtack_n=0.
REQ-009 HOLD SHALL last one cycle with strobe_n=1, direction outputs unchanged and ack=1.
REQ-010 TURN SHALL last TURN_CYCLES cycles with T_n=1, R_n=1 and a_oe=0, then go to IDLE.
REQ-011 T_n and R_n SHALL never be low in the same cycle.
REQ-012 a_oe SHALL be high only while T_n is low.
REQ-013 Between any two transfers, at least TURN_CYCLES cycles SHALL pass with T_n=R_n=1.
REQ-014 Minimum transfer latency SHALL be as follows:
- With dtack_n already low on entry to STROBE: req accepted (cycle 0), SETUP at cycle 1, STROBE at cycle 2, ack at cycle 3.
- Each extra cycle of dtack_n high adds one cycle.
REQ-015 A dtack_n low while not in STROBE SHALL be ignored.
REQ-016 The earliest new acceptance SHALL be the cycle after the last TURN cycle; with TURN_CYCLES=1 that is cycle 5.

Reset
REQ-017 While reset_n=0, the outputs SHALL be: T_n=1, R_n=1, strobe_n=1, a_oe=0, a_out=0, ack=0, err=0, busy=0, rdata=0, state=IDLE.
REQ-018 An assertion of reset_n mid-transfer SHALL release the bus immediately, without waiting for a clock edge.
REQ-019 After reset release, the first req SHALL be accepted on the first rising edge at which reset_n=1.

Configuration
REQ-020 With macro BUS_XCVR_SEQ_TIMEOUT_EN defined, timeout handling SHALL work as follows:
- An 8-bit counter clears on entry to STROBE and counts each STROBE cycle.
- When it reaches TIMEOUT with dtack_n still high, the module goes to HOLD with ack=1 and err=1.
- rdata is not updated.
REQ-021 Without BUS_XCVR_SEQ_TIMEOUT_EN, the module SHALL have no counter, err SHALL be tied to 0, and STROBE SHALL wait indefinitely.

Structure
REQ-022 Package bus_xcvr_pkg SHALL hold the state enum, the TURN_CYCLES default and the TIMEOUT default.
REQ-023 The TURN counter SHALL be 4 bits wide and SHALL be inline logic; the module SHALL have no sub-modules.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Write with wdata=8'hA5 and dtack_n low immediately -> a_out=A5 with T_n=0 on cycles 1-3, strobe_n=0 on cycle 2 only, ack on cycle 3, T_n=R_n=1 on cycle 4.
- Read with a_in=8'h3C and dtack_n low after 4 STROBE cycles -> rdata=3C, ack on cycle 6, T_n=1 throughout.
- A write immediately followed by a read with req held high -> the read is accepted on cycle 5, with R_n=1 on cycle 4 and no cycle where T_n=R_n=0.
- req pulsed during STROBE -> ignored, exactly one ack.
- reset_n low during STROBE -> T_n=R_n=strobe_n=1 and a_oe=0 at once; the next req completes normally.
- Timeout build, TIMEOUT=8, dtack_n held high -> ack=err=1 after 8 STROBE cycles, rdata unchanged.
